lcu_key_loader: RTL
===================

// Module: lcu_key_loader
// PURPOSE
//   Configuration controller for the key-locked LCU state machine. Accepts a serial
//   key stream and holds the LCU in reset while the key is loaded and checked.
//   Presents the assembled key to the LCU keyinput bus and then releases the LCU.
//   Sits between the test/boot interface and the LCU; the LCU never runs on a partial key.
// PARAMETERS
//   KEY_W    8    key width in bits; drives LCU keyinput[KEY_W-1:0]
//   TIMEOUT  255  max idle cycles between accepted beats while in SHIFT (>=1)
//   RST_HOLD 2    cycles lcu_rst stays asserted after a successful load (>=1)
// PORTS
//   clk         in   1      clock; all state updates on posedge
//   rst         in   1      reset; asynchronous, active-low (0 = reset)
//   load_start  in   1      request a (re)load; sampled in IDLE, RELEASE, ERROR
//   key_valid   in   1      serial beat valid
//   key_bit     in   1      serial beat data, LSB of key first
//   key_last    in   1      marks final beat of the stream
//   key_ready   out  1      loader accepts a beat this cycle
//   key_out     out  KEY_W  assembled key to the LCU
//   lcu_rst     out  1      active-high reset to the LCU
//   key_loaded  out  1      key applied and LCU released
//   load_err    out  1      last load failed
//   busy        out  1      SHIFT or HOLD active
// BEHAVIOUR
//   Reset values: key_ready=0, key_out=0, lcu_rst=1, key_loaded=0, load_err=0, busy=0.
//   Reset mid-operation aborts any load and returns to IDLE with the reset values above.
//   Beat accepted when key_valid && key_ready. key_valid outside SHIFT is ignored.
//   States:
//     IDLE:    lcu_rst=1. load_start -> SHIFT.
//     SHIFT:   key_ready=1, busy=1.
//              Clear shift reg, bit_cnt and timer on entry.
//              On accepted beat: sh <= {key_bit, sh[KEY_W-1:1]}; bit_cnt++; timer cleared.
//              Final beat (key_last with bit_cnt==NBEAT-1, checks passed):
//                key_out <= assembled key on the same edge -> HOLD.
//              key_last with bit_cnt!=NBEAT-1 -> ERROR.
//              NBEAT-th beat without key_last -> ERROR.
//              Timer counts cycles with no accepted beat; reaching TIMEOUT -> ERROR.
//              load_start is ignored in SHIFT.
//     HOLD:    lcu_rst=1, busy=1 for RST_HOLD cycles -> RELEASE.
//              The LCU resets with the new key stable.
//     RELEASE: lcu_rst=0, key_loaded=1.
//              load_start -> SHIFT: lcu_rst=1 and key_loaded=0 from the next cycle;
//              key_out is kept until the next successful load.
//     ERROR:   load_err=1, lcu_rst=1, key_out=0. load_start -> SHIFT, which clears load_err.
//   Latency: final beat accepted at edge N -> key_loaded=1 and lcu_rst=0 from edge N+RST_HOLD.
//   Counters saturate and never wrap. bit_cnt is $clog2(KEY_W+2) bits.
// CONFIGURATION
//   LCU_KEY_PARITY_EN defined:
//     NBEAT=KEY_W+1; the extra final beat carries even parity over the key bits.
//     Parity mismatch on the final beat -> ERROR; key_out is not updated.
//     The parity bit never enters key_out.
//   LCU_KEY_PARITY_EN undefined: NBEAT=KEY_W; no parity check.
// STRUCTURE
//   Package lcu_key_pkg:
//     state typedef {IDLE, SHIFT, HOLD, RELEASE, ERROR};
//     default KEY_W, TIMEOUT and RST_HOLD constants;
//     NBEAT function.
//   Sub-module lcu_beat_timer: saturating idle-cycle counter with clear input and
//     expiry flag; used for both TIMEOUT and RST_HOLD.
// TESTING
//   1. Reset, load_start, 8 beats of key 8'hA5 LSB-first, key_last on beat 8:
//      key_out=8'hA5 at the final edge; lcu_rst falls 2 cycles later; key_loaded=1.
//   2. key_last on beat 5 -> load_err=1, key_out=0, lcu_rst=1;
//      then load_start -> load_err clears, key_ready=1.
//   3. Stall 255 cycles mid-stream with key_valid=0 -> ERROR.
//      Stall of 254 cycles then resume -> load succeeds.
//   4. In RELEASE, load_start, then load key 8'h3C:
//      lcu_rst reasserts next cycle; key_out holds 8'hA5 until the 3C final beat.
//   5. Drop rst low during SHIFT after 4 beats:
//      all outputs return to reset values asynchronously; IDLE on release.
//   6. With LCU_KEY_PARITY_EN, key 8'hA5:
//      parity beat 0 -> success; parity beat 1 -> ERROR.

Source files
------------

// File: rtl/lcu_key_loader_pkg.sv
// Shared types and defaults for the LCU key loader; LCU_KEY_PARITY_EN adds a trailing even-parity beat.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package lcu_key_loader_pkg;

    localparam int unsigned KEY_W_DEF    = 8;
    localparam int unsigned TIMEOUT_DEF  = 255;
    localparam int unsigned RST_HOLD_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        HOLD,
        RELEASE,
        ERROR
    } state_e;

    // Beats in one key stream, including the parity beat when that check is built in.
    function automatic int unsigned nbeat(input int unsigned key_w);
`ifdef LCU_KEY_PARITY_EN
        return key_w + 1;
`else
        return key_w;
`endif
    endfunction

endpackage

// File: rtl/lcu_key_loader_if.sv
// Boot/test-side key stream plus LCU-facing key and status bundle.
// Latency: none (wires only).
// Backpressure: key_ready qualifies key_valid; beats without key_ready are dropped.
interface lcu_key_loader_if #(
    parameter int unsigned KEY_W = 8
);
    logic             load_start;
    logic             key_valid;
    logic             key_bit;
    logic             key_last;
    logic             key_ready;
    logic [KEY_W-1:0] key_out;
    logic             lcu_rst;
    logic             key_loaded;
    logic             load_err;
    logic             busy;

    modport master (
        output load_start, key_valid, key_bit, key_last,
        input  key_ready, key_out, lcu_rst, key_loaded, load_err, busy
    );

    modport slave (
        input  load_start, key_valid, key_bit, key_last,
        output key_ready, key_out, lcu_rst, key_loaded, load_err, busy
    );

endinterface

// File: rtl/lcu_beat_timer.sv
// Saturating cycle counter; expired_o flags the enabled cycle that brings the count to LIMIT.
// Latency: expired_o is combinational from the count register and en_i.
// Backpressure: none; clr_i has priority over en_i.
module lcu_beat_timer #(
    parameter int unsigned LIMIT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int unsigned      CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/lcu_key_loader.sv
// Serial key loader: holds the LCU in reset until a complete, checked key is on key_out (parity beat with LCU_KEY_PARITY_EN).
// Latency: final beat accepted at edge N -> lcu_rst low and key_loaded high from edge N+RST_HOLD.
// Backpressure: key_ready is high only while shifting; beats offered in any other state are dropped.
module lcu_key_loader
    import lcu_key_loader_pkg::*;
#(
    parameter int unsigned KEY_W    = KEY_W_DEF,
    parameter int unsigned TIMEOUT  = TIMEOUT_DEF,
    parameter int unsigned RST_HOLD = RST_HOLD_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    lcu_key_loader_if.slave bus
);
    localparam int unsigned      NBEAT    = nbeat(KEY_W);
    localparam int unsigned      CNT_W    = $clog2(KEY_W + 2);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBEAT - 1);

    state_e           state_q;
    logic [KEY_W-1:0] sh_q;
    logic [KEY_W-1:0] sh_d;
    logic [KEY_W-1:0] key_out_q;
    logic [KEY_W-1:0] final_key;
    logic [CNT_W-1:0] bit_cnt_q;
    logic             key_ready_q;
    logic             lcu_rst_q;
    logic             key_loaded_q;
    logic             load_err_q;
    logic             busy_q;

    logic in_shift;
    logic in_hold;
    logic beat;
    logic last_idx;
    logic parity_ok;
    logic idle_exp;
    logic hold_done;
    logic shift_fail;
    logic shift_done;

    assign in_shift = (state_q == SHIFT);
    assign in_hold  = (state_q == HOLD);
    assign beat     = bus.key_valid && key_ready_q;
    assign last_idx = (bit_cnt_q == LAST_IDX);
    assign sh_d     = {bus.key_bit, sh_q[KEY_W-1:1]};

`ifdef LCU_KEY_PARITY_EN
    // The key is fully shifted in before the parity beat, which never enters the register.
    assign final_key = sh_q;
    assign parity_ok = (bus.key_bit == ^sh_q);
`else
    assign final_key = sh_d;
    assign parity_ok = 1'b1;
`endif

    lcu_beat_timer #(
        .LIMIT (TIMEOUT)
    ) u_idle_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (!in_shift || beat),
        .en_i      (in_shift && !beat),
        .expired_o (idle_exp)
    );

    lcu_beat_timer #(
        .LIMIT (RST_HOLD)
    ) u_hold_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (!in_hold),
        .en_i      (in_hold),
        .expired_o (hold_done)
    );

    // key_last must coincide exactly with the final beat index, and the final beat must pass parity.
    assign shift_fail = beat ? ((bus.key_last != last_idx) || (last_idx && !parity_ok))
                             : idle_exp;
    assign shift_done = beat && last_idx && bus.key_last && parity_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sh_q         <= '0;
            bit_cnt_q    <= '0;
            key_out_q    <= '0;
            key_ready_q  <= 1'b0;
            lcu_rst_q    <= 1'b1;
            key_loaded_q <= 1'b0;
            load_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE, RELEASE, ERROR: begin
                    if (bus.load_start) begin
                        state_q      <= SHIFT;
                        sh_q         <= '0;
                        bit_cnt_q    <= '0;
                        key_ready_q  <= 1'b1;
                        busy_q       <= 1'b1;
                        lcu_rst_q    <= 1'b1;
                        key_loaded_q <= 1'b0;
                        load_err_q   <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (shift_fail) begin
                        state_q     <= ERROR;
                        key_out_q   <= '0;
                        key_ready_q <= 1'b0;
                        busy_q      <= 1'b0;
                        load_err_q  <= 1'b1;
                    end else if (shift_done) begin
                        state_q     <= HOLD;
                        key_out_q   <= final_key;
                        key_ready_q <= 1'b0;
                    end else if (beat && !last_idx) begin
                        sh_q      <= sh_d;
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (hold_done) begin
                        state_q      <= RELEASE;
                        lcu_rst_q    <= 1'b0;
                        key_loaded_q <= 1'b1;
                        busy_q       <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    key_ready_q  <= 1'b0;
                    lcu_rst_q    <= 1'b1;
                    key_loaded_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.key_ready  = key_ready_q;
    assign bus.key_out    = key_out_q;
    assign bus.lcu_rst    = lcu_rst_q;
    assign bus.key_loaded = key_loaded_q;
    assign bus.load_err   = load_err_q;
    assign bus.busy       = busy_q;

endmodule
